// File: rtl/pif_joybus_cmd_parser.sv
// rtl/pif_joybus_cmd_parser.sv - PIF RAM joybus command parser; optional macro PIF_RX_ERROR_FLAG_EN flags timeouts in the rx-length byte
module pif_joybus_cmd_parser #(
  parameter int unsigned NUM_CHANNELS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [3:0]  ram_addr,
  input  logic [31:0] ram_rdata,
  output logic        ram_wren,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  output logic        jb_cmd_valid,
  input  logic        jb_cmd_ready,
  output logic [2:0]  jb_channel,
  output logic [5:0]  jb_tx_len,
  output logic [5:0]  jb_rx_len,
  output logic [7:0]  jb_tx_data,
  output logic        jb_tx_valid,
  input  logic        jb_tx_ready,
  input  logic [7:0]  jb_rx_data,
  input  logic        jb_rx_valid,
  input  logic        jb_done,
  input  logic        jb_timeout
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RD_REQ   = 4'd1;
  localparam logic [3:0] RD_WAIT  = 4'd2;
  localparam logic [3:0] DECODE   = 4'd3;
  localparam logic [3:0] RX_LEN   = 4'd4;
  localparam logic [3:0] ISSUE    = 4'd5;
  localparam logic [3:0] TX_FETCH = 4'd6;
  localparam logic [3:0] TX_SEND  = 4'd7;
  localparam logic [3:0] RX_WAIT  = 4'd8;
  localparam logic [3:0] ERR_WB   = 4'd9;
  localparam logic [3:0] FINISH   = 4'd10;

  logic [3:0] state;
  logic [5:0] ptr, rxlen_ptr, rx_ptr, tx_len, rx_len, k, wr_addr;
  logic [2:0] chan;
  logic [7:0] byte_q, wr_byte;
  logic       want_rxlen, wr_pend, fin_pend, overrun_q;

  // Big-endian lane select: byte 0 of a word sits in [31:24]
  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] a);
    case (a)
      2'd0:    lane = w[31:24];
      2'd1:    lane = w[23:16];
      2'd2:    lane = w[15:8];
      default: lane = w[7:0];
    endcase
  endfunction

  logic [5:0] tx_addr;
  logic [7:0] rx_start8, rx_end8;
  logic [2:0] chan_inc;
  logic       rx_take, rx_end, chan_ok;

  assign tx_addr   = rxlen_ptr + 6'd1 + k;
  assign rx_start8 = {2'b00, rxlen_ptr} + 8'd1 + {2'b00, tx_len};
  assign rx_end8   = rx_start8 + {2'b00, byte_q[5:0]};
  assign chan_inc  = (chan == 3'd7) ? 3'd7 : chan + 3'd1;
  assign chan_ok   = ({29'd0, chan} < NUM_CHANNELS);
  // Strobes beyond rx_len, or after jb_done was seen, are dropped
  assign rx_take   = (state == RX_WAIT) && jb_rx_valid && (k != rx_len) && !fin_pend;
  // A byte arriving with jb_done is written before the state moves on
  assign rx_end    = (state == RX_WAIT) && (jb_done || fin_pend) && !rx_take;

`ifdef PIF_RX_ERROR_FLAG_EN
  logic       timeout_q, rx_tmo;
  logic [1:0] err_step;
  assign rx_tmo = fin_pend ? timeout_q : jb_timeout;
`else
  logic unused_timeout;
  assign unused_timeout = jb_timeout;
`endif

  // Parser sequencing: byte reads, command decode, engine handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      rxlen_ptr  <= '0;
      rx_ptr     <= '0;
      tx_len     <= '0;
      rx_len     <= '0;
      k          <= '0;
      wr_addr    <= '0;
      chan       <= '0;
      byte_q     <= '0;
      wr_byte    <= '0;
      want_rxlen <= 1'b0;
      wr_pend    <= 1'b0;
      fin_pend   <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef PIF_RX_ERROR_FLAG_EN
      timeout_q  <= 1'b0;
      err_step   <= '0;
`endif
    end else begin
      wr_pend <= rx_take;
      case (state)
        IDLE: if (start) begin
          state      <= RD_REQ;
          ptr        <= '0;
          chan       <= '0;
          overrun_q  <= 1'b0;
          want_rxlen <= 1'b0;
          fin_pend   <= 1'b0;
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          byte_q <= lane(ram_rdata, ptr[1:0]);
          state  <= want_rxlen ? RX_LEN : DECODE;
        end
        DECODE: begin
          if (ptr == 6'd63 || byte_q == 8'hFE) begin
            state <= FINISH;
          end else if (byte_q == 8'hFF || byte_q == 8'hFD) begin
            ptr   <= ptr + 6'd1;
            state <= RD_REQ;
          end else if (byte_q == 8'h00) begin
            ptr   <= ptr + 6'd1;
            chan  <= chan_inc;
            state <= RD_REQ;
          end else begin
            tx_len     <= byte_q[5:0];
            ptr        <= ptr + 6'd1;
            rxlen_ptr  <= ptr + 6'd1;
            want_rxlen <= 1'b1;
            state      <= RD_REQ;
          end
        end
        RX_LEN: begin
          want_rxlen <= 1'b0;
          rx_len     <= byte_q[5:0];
          rx_ptr     <= rx_start8[5:0];
          k          <= '0;
          if (rx_end8 > 8'd63) begin
            overrun_q <= 1'b1;
            state     <= FINISH;
          end else if (!chan_ok) begin
            ptr   <= rx_end8[5:0];
            chan  <= chan_inc;
            state <= RD_REQ;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: if (jb_cmd_ready) state <= (tx_len == 6'd0) ? RX_WAIT : TX_FETCH;
        TX_FETCH: state <= TX_SEND;
        TX_SEND: if (jb_tx_ready) begin
          if (k == tx_len - 6'd1) begin
            k     <= '0;
            state <= RX_WAIT;
          end else begin
            k     <= k + 6'd1;
            state <= TX_FETCH;
          end
        end
        RX_WAIT: begin
          if (rx_take) begin
            wr_addr <= rx_ptr + k;
            wr_byte <= jb_rx_data;
            k       <= k + 6'd1;
          end
          if (rx_end) begin
            fin_pend <= 1'b0;
            ptr      <= rx_ptr + rx_len;
            chan     <= chan_inc;
`ifdef PIF_RX_ERROR_FLAG_EN
            err_step <= '0;
            state    <= rx_tmo ? ERR_WB : RD_REQ;
`else
            state    <= RD_REQ;
`endif
          end else if (jb_done) begin
            fin_pend  <= 1'b1;
`ifdef PIF_RX_ERROR_FLAG_EN
            timeout_q <= jb_timeout;
`endif
          end
        end
`ifdef PIF_RX_ERROR_FLAG_EN
        ERR_WB: begin
          err_step <= err_step + 2'd1;
          if (err_step == 2'd1) byte_q <= lane(ram_rdata, rxlen_ptr[1:0]);
          if (err_step == 2'd2) state <= RD_REQ;
        end
`else
        ERR_WB: state <= RD_REQ;
`endif
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port: read addresses per state; DECODE/RX_LEN prefetch word 15 for the FINISH RMW
  always_comb begin
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_be    = '0;
    ram_wdata = '0;
    case (state)
      RD_REQ, RD_WAIT:   ram_addr = ptr[5:2];
      DECODE, RX_LEN:    ram_addr = 4'hF;
      TX_FETCH, TX_SEND: ram_addr = tx_addr[5:2];
      RX_WAIT: begin
        ram_addr = wr_addr[5:2];
        if (wr_pend) begin
          ram_wren  = 1'b1;
          ram_be    = 4'b1000 >> wr_addr[1:0];
          ram_wdata = {4{wr_byte}};
        end
      end
`ifdef PIF_RX_ERROR_FLAG_EN
      ERR_WB: begin
        ram_addr = rxlen_ptr[5:2];
        if (err_step == 2'd2) begin
          ram_wren  = 1'b1;
          ram_be    = 4'b1000 >> rxlen_ptr[1:0];
          ram_wdata = {4{byte_q | 8'h80}};
        end
      end
`endif
      FINISH: begin
        ram_addr  = 4'hF;
        ram_wren  = 1'b1;
        ram_be    = 4'b0001;
        ram_wdata = {4{ram_rdata[7:0] & 8'hFE}};
      end
      default: ;
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign overrun      = overrun_q;
  assign jb_cmd_valid = (state == ISSUE);
  assign jb_channel   = (state == ISSUE) ? chan : 3'd0;
  assign jb_tx_len    = (state == ISSUE) ? tx_len : 6'd0;
  assign jb_rx_len    = (state == ISSUE) ? rx_len : 6'd0;
  assign jb_tx_valid  = (state == TX_SEND);
  assign jb_tx_data   = (state == TX_SEND) ? lane(ram_rdata, tx_addr[1:0]) : 8'd0;

endmodule

// File: tb/tb_pif_joybus_cmd_parser.sv
// tb/tb_pif_joybus_cmd_parser.sv - directed self-checking bench for pif_joybus_cmd_parser
module tb_pif_joybus_cmd_parser;
  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, overrun;
  logic [3:0]  ram_addr;
  logic [31:0] ram_rdata;
  logic        ram_wren;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        jb_cmd_valid, jb_cmd_ready;
  logic [2:0]  jb_channel;
  logic [5:0]  jb_tx_len, jb_rx_len;
  logic [7:0]  jb_tx_data;
  logic        jb_tx_valid, jb_tx_ready;
  logic [7:0]  jb_rx_data;
  logic        jb_rx_valid, jb_done, jb_timeout;

  int total = 0;
  int bad = 0;
  int valid_cyc = 0;
  int wr_cyc = 0;
  int v0, w0;
  logic [7:0] mem [0:63];
  logic [7:0] img [0:63];
  logic       ld = 1'b0;
  logic [7:0] exp_flag;

  always #5 clk = ~clk;

  pif_joybus_cmd_parser #(.NUM_CHANNELS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .overrun(overrun),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wren(ram_wren), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .jb_cmd_valid(jb_cmd_valid), .jb_cmd_ready(jb_cmd_ready),
    .jb_channel(jb_channel), .jb_tx_len(jb_tx_len), .jb_rx_len(jb_rx_len),
    .jb_tx_data(jb_tx_data), .jb_tx_valid(jb_tx_valid), .jb_tx_ready(jb_tx_ready),
    .jb_rx_data(jb_rx_data), .jb_rx_valid(jb_rx_valid), .jb_done(jb_done),
    .jb_timeout(jb_timeout)
  );

  // PIF RAM model with one-cycle read latency, plus activity counters
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else if (ram_wren) begin
      if (ram_be[3]) mem[{ram_addr, 2'd0}] <= ram_wdata[31:24];
      if (ram_be[2]) mem[{ram_addr, 2'd1}] <= ram_wdata[23:16];
      if (ram_be[1]) mem[{ram_addr, 2'd2}] <= ram_wdata[15:8];
      if (ram_be[0]) mem[{ram_addr, 2'd3}] <= ram_wdata[7:0];
    end
    ram_rdata <= {mem[{ram_addr, 2'd0}], mem[{ram_addr, 2'd1}], mem[{ram_addr, 2'd2}], mem[{ram_addr, 2'd3}]};
    if (jb_cmd_valid) valid_cyc <= valid_cyc + 1;
    if (ram_wren) wr_cyc <= wr_cyc + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 64; i++) img[i] = 8'h33;
    img[63] = 8'h01;
  endtask

  task automatic load();
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 600) begin tick(); n++; end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (!jb_cmd_valid && n < 600) begin tick(); n++; end
    chk(tag, {31'd0, jb_cmd_valid}, 32'd1);
  endtask

  task automatic accept_cmd();
    jb_cmd_ready = 1'b1;
    tick();
    jb_cmd_ready = 1'b0;
  endtask

  task automatic tx_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!jb_tx_valid && n < 100) begin tick(); n++; end
    chk(tag, {24'd0, jb_tx_data}, {24'd0, exp});
    jb_tx_ready = 1'b1;
    tick();
    jb_tx_ready = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic fin);
    jb_rx_valid = 1'b1;
    jb_rx_data  = d;
    jb_done     = fin;
    tick();
    jb_rx_valid = 1'b0;
    jb_done     = 1'b0;
  endtask

  task automatic eng_done(input logic tmo);
    jb_done    = 1'b1;
    jb_timeout = tmo;
    tick();
    jb_done    = 1'b0;
    jb_timeout = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    reset = 1'b1; start = 1'b0; jb_cmd_ready = 1'b0; jb_tx_ready = 1'b0;
    jb_rx_data = 8'd0; jb_rx_valid = 1'b0; jb_done = 1'b0; jb_timeout = 1'b0;
    fill();
    load();
    repeat (3) tick();
    chk("rst_flags", {26'd0, busy, done, overrun, jb_cmd_valid, jb_tx_valid, ram_wren}, 32'd0);
    chk("rst_ram", {ram_addr, ram_be, 24'd0}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // Empty block: busy at start+1, done at start+4
    fill(); img[0] = 8'hFE; load();
    pulse_start();
    chk("empty_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    chk("empty_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("empty_done_at4", {31'd0, done}, 32'd1);
    tick();
    chk("empty_ctrl", {24'd0, mem[63]}, 32'h00);
    chk("empty_idle", {31'd0, busy}, 32'd0);

    // FF FF FE: no command, control bit cleared
    fill(); img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'hFE; img[63] = 8'h03; load();
    v0 = valid_cyc;
    pulse_start();
    wait_done("ff_done");
    tick();
    chk("ff_nocmd", valid_cyc - v0, 32'd0);
    chk("ff_ctrl", {24'd0, mem[63]}, 32'h02);
    chk("ff_byte0", {24'd0, mem[0]}, 32'hFF);

    // Controller status: 01 04 00, engine returns 05 00 02 (last byte with jb_done)
    fill(); img[0] = 8'h01; img[1] = 8'h04; img[2] = 8'h00;
    for (int i = 3; i < 7; i++) img[i] = 8'hAA;
    img[7] = 8'hFE; load();
    pulse_start();
    wait_cmd("st_cmd");
    chk("st_fields", {23'd0, jb_channel, jb_tx_len, jb_rx_len}, {23'd0, 3'd0, 6'd1, 6'd4});
    accept_cmd();
    tx_byte("st_tx", 8'h00);
    rx_byte(8'h05, 1'b0);
    rx_byte(8'h00, 1'b0);
    rx_byte(8'h02, 1'b1);
    wait_done("st_done");
    tick();
    chk("st_rx", {8'd0, mem[3], mem[4], mem[5]}, 32'h050002);
    chk("st_b6", {24'd0, mem[6]}, 32'hAA);
    chk("st_ctrl", {24'd0, mem[63]}, 32'h00);

    // 00 00 01 03 00: single command on channel 2
    fill(); img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h01; img[3] = 8'h03; img[4] = 8'h00;
    img[5] = 8'hFE; img[8] = 8'hFE; load();
    v0 = valid_cyc;
    pulse_start();
    wait_cmd("c2_cmd");
    chk("c2_fields", {23'd0, jb_channel, jb_tx_len, jb_rx_len}, {23'd0, 3'd2, 6'd1, 6'd3});
    accept_cmd();
    tx_byte("c2_tx", 8'h00);
    eng_done(1'b0);
    wait_done("c2_done");
    tick();
    chk("c2_onecmd", valid_cyc - v0, 32'd1);
    chk("c2_rxkeep", {8'd0, mem[5], mem[6], mem[7]}, 32'hFE3333);

    // Channel 5 is parsed but not issued
    fill();
    for (int i = 0; i < 5; i++) img[i] = 8'h00;
    img[5] = 8'h01; img[6] = 8'h01; img[7] = 8'h44; img[9] = 8'hFE; load();
    v0 = valid_cyc;
    pulse_start();
    wait_done("oor_done");
    tick();
    chk("oor_nocmd", valid_cyc - v0, 32'd0);
    chk("oor_rxkeep", {24'd0, mem[8]}, 32'h33);

    // tx_len 0x3F at byte 0: overrun, no command, only the control write
    fill(); img[0] = 8'h3F; load();
    v0 = valid_cyc; w0 = wr_cyc;
    pulse_start();
    wait_done("ovr_done");
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    tick();
    chk("ovr_nocmd", valid_cyc - v0, 32'd0);
    chk("ovr_writes", wr_cyc - w0, 32'd1);
    chk("ovr_ctrl", {24'd0, mem[63]}, 32'h00);
    repeat (3) tick();
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    fill(); img[0] = 8'hFE; load();
    pulse_start();
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    wait_done("ovr_done2");
    tick();

    // Command ending exactly at byte 63 is legal; byte 63 then ends the parse
    fill();
    for (int i = 0; i < 60; i++) img[i] = 8'hFF;
    img[60] = 8'h01; img[61] = 8'h00; img[62] = 8'h5C; load();
    pulse_start();
    wait_cmd("edge_cmd");
    chk("edge_fields", {23'd0, jb_channel, jb_tx_len, jb_rx_len}, {23'd0, 3'd0, 6'd1, 6'd0});
    accept_cmd();
    tx_byte("edge_tx", 8'h5C);
    eng_done(1'b0);
    wait_done("edge_done");
    chk("edge_novr", {31'd0, overrun}, 32'd0);
    tick();
    chk("edge_ctrl", {24'd0, mem[63]}, 32'h00);

    // Timeout with no rx bytes
    fill(); img[0] = 8'h01; img[1] = 8'h04; img[2] = 8'h00; img[7] = 8'hFE; load();
    pulse_start();
    wait_cmd("tmo_cmd");
    accept_cmd();
    tx_byte("tmo_tx", 8'h00);
    eng_done(1'b1);
    wait_done("tmo_done");
    tick();
`ifdef PIF_RX_ERROR_FLAG_EN
    exp_flag = 8'h84;
`else
    exp_flag = 8'h04;
`endif
    chk("tmo_rxlen", {24'd0, mem[1]}, {24'd0, exp_flag});
    chk("tmo_rxkeep", {24'd0, mem[3]}, 32'h33);

    // Two tx bytes, rx_len 1; second strobe (with jb_done) is dropped
    fill(); img[0] = 8'h02; img[1] = 8'h01; img[2] = 8'h11; img[3] = 8'h22; img[5] = 8'hFE; load();
    pulse_start();
    wait_cmd("drop_cmd");
    accept_cmd();
    tx_byte("drop_tx0", 8'h11);
    tx_byte("drop_tx1", 8'h22);
    rx_byte(8'hAB, 1'b0);
    rx_byte(8'hCD, 1'b1);
    wait_done("drop_done");
    tick();
    chk("drop_rx", {24'd0, mem[4]}, 32'hAB);
    chk("drop_next", {24'd0, mem[5]}, 32'hFE);

    // Reset while waiting in TX_SEND
    load();
    pulse_start();
    wait_cmd("rst_cmd");
    accept_cmd();
    begin
      int n = 0;
      while (!jb_tx_valid && n < 100) begin tick(); n++; end
    end
    chk("rst_txv", {31'd0, jb_tx_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rstmid_flags", {26'd0, busy, done, overrun, jb_cmd_valid, jb_tx_valid, ram_wren}, 32'd0);
    chk("rstmid_ram", {ram_addr, ram_be, 24'd0}, 32'd0);
    chk("rstmid_jb", {9'd0, jb_channel, jb_tx_len, jb_rx_len, jb_tx_data}, 32'd0);
    chk("rstmid_wdata", ram_wdata, 32'd0);
    reset = 1'b0;
    w0 = wr_cyc;
    repeat (20) tick();
    chk("rstmid_nowr", wr_cyc - w0, 32'd0);
    chk("rstmid_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
